// File: rtl/regfile_access_arbiter_pkg.sv
// Shared op codes, FSM state encoding and requester ids for the
// register-file debug-port arbiter.
package regfile_access_arbiter_pkg;

  // Settle counter width; SETTLE_CYCLES must fit (1..15).
  localparam int SETTLE_W = 4;

  // Requester ids, also used as the grant vector bit index.
  localparam logic REQ_CTL = 1'b0;
  localparam logic REQ_FIM = 1'b1;

  typedef enum logic [1:0] {
    ARB_OP_READ  = 2'b00,
    ARB_OP_WRITE = 2'b01,
    ARB_OP_FLIP  = 2'b10,
    ARB_OP_RSVD  = 2'b11
  } arb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STOP_WAIT = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_FLIP_WB   = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_e;

  // Settle counter load value: STOP_WAIT lasts exactly `settle` cycles.
  function automatic logic [SETTLE_W-1:0] settle_load(input int settle);
    return SETTLE_W'(settle - 1);
  endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. On a tie the requester not granted last wins;
// the pointer only moves when a grant is actually accepted.
module rr_arbiter2
  import regfile_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // prio_q names the requester favoured on a tie (reset favours CTL)
  logic prio_q, prio_d;

  // Grant: single requester wins outright, tie resolved by prio_q
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt         = 2'b00;
      gnt[prio_q] = 1'b1;
    end
  end

  // After an accepted grant, favour the other requester next time
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = gnt[REQ_CTL] ? REQ_FIM : REQ_CTL;
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= REQ_CTL;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the core's register-file debug port between soc_control (CTL) and
// the fault injection module (FIM). Each granted request stalls the CPU,
// waits a settle interval, performs READ / WRITE / FLIP (read-xor-write),
// answers the winner, then releases the CPU. All cm_* and response outputs
// are registered and decoded from the next state.
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SETTLE_CYCLES  = 1
)(
  input  logic                      clk,
  input  logic                      rst,
  // CTL requester
  input  logic                      ctl_req_valid,
  output logic                      ctl_req_ready,
  input  logic [1:0]                ctl_req_op,
  input  logic [REG_ADDR_WIDTH-1:0] ctl_req_addr,
  input  logic [DATA_WIDTH-1:0]     ctl_req_data,
  output logic                      ctl_rsp_valid,
  input  logic                      ctl_rsp_ready,
  output logic [DATA_WIDTH-1:0]     ctl_rsp_data,
  output logic                      ctl_rsp_err,
  // FIM requester
  input  logic                      fim_req_valid,
  output logic                      fim_req_ready,
  input  logic [1:0]                fim_req_op,
  input  logic [REG_ADDR_WIDTH-1:0] fim_req_addr,
  input  logic [DATA_WIDTH-1:0]     fim_req_data,
  output logic                      fim_rsp_valid,
  input  logic                      fim_rsp_ready,
  output logic [DATA_WIDTH-1:0]     fim_rsp_data,
  output logic                      fim_rsp_err,
  // core register-file port
  output logic                      cm_cpu_stop,
  output logic                      cm_regfile_we,
  output logic [REG_ADDR_WIDTH-1:0] cm_regfile_addr,
  output logic [DATA_WIDTH-1:0]     cm_write_regfile_dat,
  input  logic [DATA_WIDTH-1:0]     cm_read_regfile_dat
);

  arb_state_e                state_q, state_d;
  logic [SETTLE_W-1:0]       cnt_q, cnt_d;
  logic                      win_q, win_d;
  arb_op_e                   op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      ctl_rsp_valid_q, ctl_rsp_valid_d;
  logic                      fim_rsp_valid_q, fim_rsp_valid_d;
  logic                      cm_cpu_stop_q, cm_cpu_stop_d;
  logic                      cm_regfile_we_q, cm_regfile_we_d;
  logic [REG_ADDR_WIDTH-1:0] cm_regfile_addr_q, cm_regfile_addr_d;
  logic [DATA_WIDTH-1:0]     cm_write_regfile_dat_q, cm_write_regfile_dat_d;

  logic       idle;
  logic [1:0] gnt;
  logic       hs;
  logic       addr_nz;
  logic       win_rsp_ready;

  assign idle    = (state_q == ST_IDLE);
  assign hs      = idle & (|gnt);
  assign addr_nz = (addr_q != '0);
  assign win_rsp_ready = (win_q == REQ_FIM) ? fim_rsp_ready : ctl_rsp_ready;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({fim_req_valid, ctl_req_valid}),
    .accept (hs),
    .gnt    (gnt)
  );

  // Request handshake: only offered in IDLE, only to the granted requester
  assign ctl_req_ready = idle & gnt[REQ_CTL];
  assign fim_req_ready = idle & gnt[REQ_FIM];

  // Next-state, latching and registered output decode
  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    win_d                  = win_q;
    op_d                   = op_q;
    addr_d                 = addr_q;
    data_d                 = data_q;
    rsp_data_d             = rsp_data_q;
    rsp_err_d              = rsp_err_q;
    ctl_rsp_valid_d        = ctl_rsp_valid_q;
    fim_rsp_valid_d        = fim_rsp_valid_q;
    cm_regfile_we_d        = 1'b0;
    cm_regfile_addr_d      = '0;
    cm_write_regfile_dat_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          win_d      = gnt[REQ_FIM];
          op_d       = arb_op_e'(gnt[REQ_FIM] ? fim_req_op   : ctl_req_op);
          addr_d     = gnt[REQ_FIM] ? fim_req_addr : ctl_req_addr;
          data_d     = gnt[REQ_FIM] ? fim_req_data : ctl_req_data;
          cnt_d      = settle_load(SETTLE_CYCLES);
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ST_STOP_WAIT;
        end
      end

      ST_STOP_WAIT: begin
        if (cnt_q == '0) begin
          // Present the access for the ACCESS cycle; x0 is never written
          state_d                = ST_ACCESS;
          cm_regfile_addr_d      = addr_q;
          cm_regfile_we_d        = (op_q == ARB_OP_WRITE) && addr_nz;
          cm_write_regfile_dat_d = (op_q == ARB_OP_WRITE) ? data_q : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_ACCESS: begin
        // Read data is the pre-write value; x0 and reserved answer zero
        rsp_data_d = (addr_nz && op_q != ARB_OP_RSVD) ? cm_read_regfile_dat : '0;
        rsp_err_d  = (op_q == ARB_OP_RSVD);
        if (op_q == ARB_OP_FLIP) begin
          state_d                = ST_FLIP_WB;
          cm_regfile_addr_d      = addr_q;
          cm_regfile_we_d        = addr_nz;
          cm_write_regfile_dat_d = addr_nz ? (cm_read_regfile_dat ^ data_q) : '0;
        end else begin
          state_d         = ST_RESP;
          ctl_rsp_valid_d = (win_q == REQ_CTL);
          fim_rsp_valid_d = (win_q == REQ_FIM);
        end
      end

      ST_FLIP_WB: begin
        state_d         = ST_RESP;
        ctl_rsp_valid_d = (win_q == REQ_CTL);
        fim_rsp_valid_d = (win_q == REQ_FIM);
      end

      ST_RESP: begin
        if (win_rsp_ready) begin
          state_d         = ST_IDLE;
          ctl_rsp_valid_d = 1'b0;
          fim_rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Core is stalled in every non-IDLE state, so IDLE always gives it a cycle
    cm_cpu_stop_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                <= ST_IDLE;
      cnt_q                  <= '0;
      win_q                  <= REQ_CTL;
      op_q                   <= ARB_OP_READ;
      addr_q                 <= '0;
      data_q                 <= '0;
      rsp_data_q             <= '0;
      rsp_err_q              <= 1'b0;
      ctl_rsp_valid_q        <= 1'b0;
      fim_rsp_valid_q        <= 1'b0;
      cm_cpu_stop_q          <= 1'b0;
      cm_regfile_we_q        <= 1'b0;
      cm_regfile_addr_q      <= '0;
      cm_write_regfile_dat_q <= '0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      win_q                  <= win_d;
      op_q                   <= op_d;
      addr_q                 <= addr_d;
      data_q                 <= data_d;
      rsp_data_q             <= rsp_data_d;
      rsp_err_q              <= rsp_err_d;
      ctl_rsp_valid_q        <= ctl_rsp_valid_d;
      fim_rsp_valid_q        <= fim_rsp_valid_d;
      cm_cpu_stop_q          <= cm_cpu_stop_d;
      cm_regfile_we_q        <= cm_regfile_we_d;
      cm_regfile_addr_q      <= cm_regfile_addr_d;
      cm_write_regfile_dat_q <= cm_write_regfile_dat_d;
    end
  end

  // Responses are only visible to the winner
  assign ctl_rsp_valid        = ctl_rsp_valid_q;
  assign fim_rsp_valid        = fim_rsp_valid_q;
  assign ctl_rsp_data         = ctl_rsp_valid_q ? rsp_data_q : '0;
  assign fim_rsp_data         = fim_rsp_valid_q ? rsp_data_q : '0;
  assign ctl_rsp_err          = ctl_rsp_valid_q & rsp_err_q;
  assign fim_rsp_err          = fim_rsp_valid_q & rsp_err_q;
  assign cm_cpu_stop          = cm_cpu_stop_q;
  assign cm_regfile_we        = cm_regfile_we_q;
  assign cm_regfile_addr      = cm_regfile_addr_q;
  assign cm_write_regfile_dat = cm_write_regfile_dat_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomized bench for regfile_access_arbiter with a transaction-level
// reference model (register array + round-robin winner + latency formula).
module tb_regfile_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int S  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctl_req_valid = 0, ctl_req_ready, ctl_rsp_valid, ctl_rsp_ready = 0, ctl_rsp_err;
  logic [1:0]    ctl_req_op = 0;
  logic [AW-1:0] ctl_req_addr = 0;
  logic [DW-1:0] ctl_req_data = 0, ctl_rsp_data;
  logic          fim_req_valid = 0, fim_req_ready, fim_rsp_valid, fim_rsp_ready = 0, fim_rsp_err;
  logic [1:0]    fim_req_op = 0;
  logic [AW-1:0] fim_req_addr = 0;
  logic [DW-1:0] fim_req_data = 0, fim_rsp_data;
  logic          cm_cpu_stop, cm_regfile_we;
  logic [AW-1:0] cm_regfile_addr;
  logic [DW-1:0] cm_write_regfile_dat, cm_read_regfile_dat;

  regfile_access_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .ctl_req_valid(ctl_req_valid), .ctl_req_ready(ctl_req_ready), .ctl_req_op(ctl_req_op),
    .ctl_req_addr(ctl_req_addr), .ctl_req_data(ctl_req_data), .ctl_rsp_valid(ctl_rsp_valid),
    .ctl_rsp_ready(ctl_rsp_ready), .ctl_rsp_data(ctl_rsp_data), .ctl_rsp_err(ctl_rsp_err),
    .fim_req_valid(fim_req_valid), .fim_req_ready(fim_req_ready), .fim_req_op(fim_req_op),
    .fim_req_addr(fim_req_addr), .fim_req_data(fim_req_data), .fim_rsp_valid(fim_rsp_valid),
    .fim_rsp_ready(fim_rsp_ready), .fim_rsp_data(fim_rsp_data), .fim_rsp_err(fim_rsp_err),
    .cm_cpu_stop(cm_cpu_stop), .cm_regfile_we(cm_regfile_we), .cm_regfile_addr(cm_regfile_addr),
    .cm_write_regfile_dat(cm_write_regfile_dat), .cm_read_regfile_dat(cm_read_regfile_dat)
  );

  always #5 clk = ~clk;

  // Core register file stand-in: combinational read, write on clock
  logic [DW-1:0] tb_rf [32];
  logic [DW-1:0] m_regs [32];
  int we_cnt = 0, x0_wr = 0;
  assign cm_read_regfile_dat = tb_rf[cm_regfile_addr];
  always @(posedge clk) begin
    if (cm_regfile_we) begin
      we_cnt++;
      if (cm_regfile_addr == '0) x0_wr++;
      else tb_rf[cm_regfile_addr] <= cm_write_regfile_dat;
    end
  end

  int n_vec = 0, n_err = 0;
  int prio = 0;  // requester favoured on a tie: 0 CTL, 1 FIM

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int who, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin ctl_req_op = op; ctl_req_addr = a; ctl_req_data = d; end
    else          begin fim_req_op = op; fim_req_addr = a; fim_req_data = d; end
  endtask

  task automatic do_txn(input bit cv, input bit fv, input int hold);
    int w, cyc, stall, we0, exp_we, exp_cyc;
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, old, exp_rsp;
    bit exp_err;
    @(negedge clk);
    ctl_req_valid = cv; fim_req_valid = fv;
    #1;
    w = (cv && fv) ? prio : (cv ? 0 : 1);
    chk("ctl_ready", {31'd0, ctl_req_ready}, (w == 0) ? 1 : 0);
    chk("fim_ready", {31'd0, fim_req_ready}, (w == 1) ? 1 : 0);
    chk("idle_stop", {31'd0, cm_cpu_stop}, 0);
    op = w ? fim_req_op : ctl_req_op;
    a  = w ? fim_req_addr : ctl_req_addr;
    d  = w ? fim_req_data : ctl_req_data;
    prio = (w == 0) ? 1 : 0;
    // Reference result
    old = (a == 0) ? '0 : m_regs[a];
    exp_err = (op == 2'b11);
    exp_rsp = exp_err ? '0 : old;
    exp_we  = 0;
    if (a != 0 && op == 2'b01) begin m_regs[a] = d;       exp_we = 1; end
    if (a != 0 && op == 2'b10) begin m_regs[a] = old ^ d; exp_we = 1; end
    exp_cyc = S + ((op == 2'b10) ? 2 : 1) + 1;
    we0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    // Winner's inputs must be ignored once latched
    if (w == 0) begin ctl_req_valid = 0; set_req(0, 2'($urandom), AW'($urandom), $urandom); end
    else        begin fim_req_valid = 0; set_req(1, 2'($urandom), AW'($urandom), $urandom); end
    #1;
    chk("busy_ready", {30'd0, ctl_req_ready, fim_req_ready}, 0);
    cyc = 1; stall = 0;
    while (!(w ? fim_rsp_valid : ctl_rsp_valid) && cyc < 40) begin
      stall += int'(cm_cpu_stop);
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", cyc, exp_cyc);
    chk("stall_cycles", stall, cyc - 1);
    if (cyc >= 40) begin ctl_req_valid = 0; fim_req_valid = 0; return; end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid", {31'd0, w ? fim_rsp_valid : ctl_rsp_valid}, 1);
      chk("loser_valid", {31'd0, w ? ctl_rsp_valid : fim_rsp_valid}, 0);
      chk("rsp_err", {31'd0, w ? fim_rsp_err : ctl_rsp_err}, {31'd0, exp_err});
      if (!exp_err) chk("rsp_data", w ? fim_rsp_data : ctl_rsp_data, exp_rsp);
      chk("resp_stop", {31'd0, cm_cpu_stop}, 1);
    end
    if (w == 0) ctl_rsp_ready = 1; else fim_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    ctl_rsp_ready = 0; fim_rsp_ready = 0;
    ctl_req_valid = 0; fim_req_valid = 0;
    #1;
    chk("release_stop", {31'd0, cm_cpu_stop}, 0);
    chk("release_valid", {30'd0, ctl_rsp_valid, fim_rsp_valid}, 0);
    chk("we_pulses", we_cnt - we0, exp_we);
    chk("reg_value", tb_rf[a], m_regs[a]);
    chk("x0_writes", x0_wr, 0);
  endtask

  initial begin
    int we0;
    for (int i = 0; i < 32; i++) tb_rf[i] = $urandom;
    tb_rf[0] = '0; tb_rf[5] = 32'hDEADBEEF; tb_rf[7] = 32'h0000_00F0;
    for (int i = 0; i < 32; i++) m_regs[i] = tb_rf[i];

    #1;
    chk("rst_stop", {31'd0, cm_cpu_stop}, 0);
    chk("rst_we", {31'd0, cm_regfile_we}, 0);
    chk("rst_addr", {27'd0, cm_regfile_addr}, 0);
    chk("rst_wdat", cm_write_regfile_dat, 0);
    chk("rst_rsp", {28'd0, ctl_rsp_valid, fim_rsp_valid, ctl_rsp_err, fim_rsp_err}, 0);
    chk("rst_ready", {30'd0, ctl_req_ready, fim_req_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    // Directed cases
    set_req(0, 2'b00, 5'd5, 32'h0);          do_txn(1, 0, 0);
    set_req(1, 2'b10, 5'd7, 32'h0000_0011);  do_txn(0, 1, 1);
    set_req(0, 2'b01, 5'd0, 32'h0000_1234);  do_txn(1, 0, 0);

    // Fresh reset, then simultaneous pairs: CTL first, then FIM
    @(negedge clk); rst = 0; prio = 0;
    @(negedge clk); rst = 1;
    set_req(0, 2'b00, 5'd9, 32'h0); set_req(1, 2'b00, 5'd10, 32'h0);
    do_txn(1, 1, 0);
    do_txn(1, 1, 0);
    set_req(0, 2'b01, 5'd11, 32'hA5A5_0001); set_req(1, 2'b01, 5'd12, 32'h5A5A_0002);
    do_txn(1, 1, 0);

    // Reserved op from FIM with a slow response consumer
    set_req(1, 2'b11, 5'd3, 32'hFFFF_FFFF); do_txn(0, 1, 5);

    // Reset during STOP_WAIT of a FLIP aborts it
    set_req(1, 2'b10, 5'd7, 32'hFFFF_0000);
    @(negedge clk); fim_req_valid = 1;
    @(posedge clk);
    @(negedge clk); fim_req_valid = 0;
    we0 = we_cnt;
    rst = 0;
    #1;
    chk("abort_stop", {31'd0, cm_cpu_stop}, 0);
    chk("abort_we", {31'd0, cm_regfile_we}, 0);
    chk("abort_addr", {27'd0, cm_regfile_addr}, 0);
    chk("abort_rsp", {30'd0, ctl_rsp_valid, fim_rsp_valid}, 0);
    repeat (3) @(negedge clk);
    rst = 1; prio = 0;
    repeat (S + 3) @(negedge clk);
    chk("abort_no_we", we_cnt - we0, 0);
    chk("abort_no_rsp", {30'd0, ctl_rsp_valid, fim_rsp_valid}, 0);
    chk("abort_reg", tb_rf[7], m_regs[7]);
    set_req(0, 2'b00, 5'd7, 32'h0); do_txn(1, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++)
        set_req(r, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom),
                $urandom);
      do_txn(sel[0], sel[1], $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
